// File: rtl/mic_array_pkg.sv
// Shared types and helpers for the mic-array serial hub.
// Optional parity is enabled by defining MIC_ARRAY_PARITY_EN.
package mic_array_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StGap,
        StRsp
    } hub_state_e;

`ifdef MIC_ARRAY_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    // Bits per transfer on the wire, including the optional parity bit.
    function automatic int unsigned nbits(input int unsigned data_w);
        return data_w + PAR_BITS;
    endfunction

    // Odd parity: the returned bit makes the total count of ones odd.
    // Zero-extension of narrower words leaves the result unchanged.
    function automatic logic odd_parity(input logic [31:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/mic_array_sclk_gen.sv
// Serial clock phase generator: CLK_DIV cycles per half-period, held clear while not running.
module mic_array_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    output logic rise_pulse_o,
    output logic fall_pulse_o,
    output logic sclk_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             phase_end;

    always_comb begin
        phase_end    = (cnt_q == CNT_W'(CLK_DIV - 1));
        rise_pulse_o = run_i & ~sclk_q & phase_end;
        fall_pulse_o = run_i & sclk_q & phase_end;
        cnt_d        = (!run_i || phase_end) ? '0 : cnt_q + CNT_W'(1);
        sclk_d       = run_i ? (sclk_q ^ phase_end) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/mic_array_serial_hub.sv
// N-channel lock-step serial command engine with per-channel reply capture.
// Define MIC_ARRAY_PARITY_EN to append and check an odd-parity bit.
module mic_array_serial_hub
    import mic_array_pkg::*;
#(
    parameter int unsigned N_CH    = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [N_CH-1:0]        cmd_chan_mask,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [N_CH*DATA_W-1:0] rsp_data,
    output logic [N_CH-1:0]        rsp_err,
    output logic [N_CH-1:0]        busy_out,
    output logic [N_CH-1:0]        serial_clk_out,
    output logic [N_CH-1:0]        serial_data_out,
    input  logic [N_CH-1:0]        serial_data_in
);

    localparam int unsigned NBITS  = nbits(DATA_W);
    localparam int unsigned BCNT_W = $clog2(NBITS + 1);
    localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    hub_state_e        state_q, state_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]  tx_q, tx_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic accept;
    logic run;
    logic busy;
    logic sample;
    logic rise_pulse;
    logic fall_pulse;
    logic sclk;

    assign cmd_ready = (state_q == StIdle) & reset_n;
    assign accept    = cmd_valid & cmd_ready;
    assign run       = (state_q == StLo) || (state_q == StHi);
    assign busy      = run || (state_q == StGap);
    assign sample    = (state_q == StLo) & rise_pulse;
    assign rsp_valid = (state_q == StRsp);

    mic_array_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .run_i        (run),
        .rise_pulse_o (rise_pulse),
        .fall_pulse_o (fall_pulse),
        .sclk_o       (sclk)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        mask_d    = mask_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mask_d    = cmd_chan_mask;
`ifdef MIC_ARRAY_PARITY_EN
                    tx_d      = {cmd_data, odd_parity(32'(cmd_data))};
`else
                    tx_d      = cmd_data;
`endif
                    bit_cnt_d = BCNT_W'(NBITS);
                    gap_cnt_d = '0;
                    // An empty mask has nothing to shift: respond immediately.
                    state_d   = (|cmd_chan_mask) ? StLo : StRsp;
                end
            end
            StLo: begin
                if (rise_pulse) begin
                    state_d = StHi;
                end
            end
            StHi: begin
                if (fall_pulse) begin
                    bit_cnt_d = bit_cnt_q - BCNT_W'(1);
                    tx_d      = tx_q << 1;
                    if (bit_cnt_q == BCNT_W'(1)) begin
                        state_d = (GAP_CYC == 0) ? StRsp : StGap;
                    end else begin
                        state_d = StLo;
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            mask_q    <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            mask_q    <= mask_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign busy_out        = {N_CH{busy}} & mask_q;
    assign serial_clk_out  = {N_CH{sclk}} & mask_q;
    assign serial_data_out = {N_CH{run & tx_q[NBITS-1]}} & mask_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [NBITS-1:0] rx_q, rx_d;

        always_comb begin
            rx_d = rx_q;
            if (accept) begin
                rx_d = '0;
            end else if (sample && mask_q[k]) begin
                rx_d = {rx_q[NBITS-2:0], serial_data_in[k]};
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rx_q <= '0;
            end else begin
                rx_q <= rx_d;
            end
        end

        // Data occupies the top DATA_W bits; a parity bit, if present, is the LSB.
        assign rsp_data[k*DATA_W +: DATA_W] = rsp_valid ? rx_q[NBITS-1 -: DATA_W] : '0;

`ifdef MIC_ARRAY_PARITY_EN
        assign rsp_err[k] = rsp_valid & mask_q[k] &
                            (rx_q[0] != odd_parity(32'(rx_q[NBITS-1 -: DATA_W])));
`else
        assign rsp_err[k] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mic_array_serial_hub.sv
// Randomised self-checking bench for mic_array_serial_hub against a transaction-level model.
// Honours MIC_ARRAY_PARITY_EN for the parity scenario.
module tb_mic_array_serial_hub;

    localparam int N_CH    = 4;
    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 3;
`ifdef MIC_ARRAY_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam logic [N_CH-1:0] PAR_ON = (NB > DATA_W) ? {N_CH{1'b1}} : '0;

    logic                   clk;
    logic                   reset_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [N_CH-1:0]        cmd_chan_mask;
    logic [DATA_W-1:0]      cmd_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [N_CH*DATA_W-1:0] rsp_data;
    logic [N_CH-1:0]        rsp_err;
    logic [N_CH-1:0]        busy_out;
    logic [N_CH-1:0]        serial_clk_out;
    logic [N_CH-1:0]        serial_data_out;
    logic [N_CH-1:0]        serial_data_in;

    mic_array_serial_hub #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_chan_mask   (cmd_chan_mask),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .busy_out        (busy_out),
        .serial_clk_out  (serial_clk_out),
        .serial_data_out (serial_data_out),
        .serial_data_in  (serial_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel reply: {word, parity}; only the first NB bits go on the wire.
    logic [DATA_W:0]   words [N_CH];
    logic [N_CH-1:0]   inv_par;
    logic [N_CH-1:0]   loop_en;
    logic [N_CH-1:0]   drive_bits;
    logic [N_CH-1:0]   cur_mask;
    logic [N_CH-1:0]   prev_sclk;
    int                rises [N_CH];
    int                lock_bad;
    int                busy_bad;
    int                total;
    int                bad;

    always_comb begin
        serial_data_in = '0;
        for (int k = 0; k < N_CH; k++) begin
            serial_data_in[k] = loop_en[k] ? serial_data_out[k] : drive_bits[k];
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic odd_bit(input logic [DATA_W-1:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    task automatic set_word(input int k, input logic [DATA_W-1:0] w, input logic inv);
        words[k]   = {w, odd_bit(w) ^ inv};
        inv_par[k] = inv;
    endtask

    task automatic mon_reset(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] loop);
        cur_mask  = mask;
        loop_en   = loop;
        prev_sclk = '0;
        lock_bad  = 0;
        busy_bad  = 0;
        for (int k = 0; k < N_CH; k++) begin
            rises[k]      = 0;
            drive_bits[k] = words[k][DATA_W];
        end
    endtask

    // Called once per falling edge: count sclk rises, check lock-step and busy, present next bit.
    task automatic monitor();
        logic [N_CH-1:0] exp_busy;
        for (int k = 0; k < N_CH; k++) begin
            if (serial_clk_out[k] && !prev_sclk[k]) rises[k]++;
        end
        prev_sclk = serial_clk_out;
        if (serial_clk_out != '0 && serial_clk_out != cur_mask) lock_bad++;
        if ((serial_data_out & ~cur_mask) != '0) lock_bad++;
        exp_busy = rsp_valid ? '0 : cur_mask;
        if (busy_out !== exp_busy) busy_bad++;
        for (int k = 0; k < N_CH; k++) begin
            drive_bits[k] = (rises[k] < NB) ? words[k][DATA_W - rises[k]] : 1'b0;
        end
    endtask

    task automatic run_txn(input string tag, input logic [N_CH-1:0] mask,
                           input logic [DATA_W-1:0] data, input logic [N_CH-1:0] loop,
                           input int hold, input bit pend);
        int                     lat;
        int                     exp_lat;
        int                     stab_bad;
        logic [N_CH*DATA_W-1:0] exp_data;
        logic [N_CH-1:0]        exp_err;
        logic [N_CH*DATA_W-1:0] snap_data;
        logic [N_CH-1:0]        snap_err;

        mon_reset(mask, loop);
        check_eq({tag, "_rdy"}, cmd_ready, 1'b1);
        cmd_valid     = 1'b1;
        cmd_chan_mask = mask;
        cmd_data      = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        forever begin
            monitor();
            if (rsp_valid || lat >= 2000) break;
            @(negedge clk);
            lat++;
        end

        exp_lat  = (mask == '0) ? 1 : 2 * CLK_DIV * NB + GAP_CYC + 1;
        exp_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (mask[k]) exp_data[k*DATA_W +: DATA_W] = loop[k] ? data : words[k][DATA_W:1];
        end
        exp_err = mask & ~loop & inv_par & PAR_ON;

        check_eq({tag, "_lat"}, lat, exp_lat);
        for (int k = 0; k < N_CH; k++) begin
            check_eq($sformatf("%s_rises%0d", tag, k), rises[k], mask[k] ? NB : 0);
        end
        check_eq({tag, "_lockstep"}, lock_bad, 0);
        check_eq({tag, "_busy"}, busy_bad, 0);
        check_eq({tag, "_data"}, rsp_data, exp_data);
        check_eq({tag, "_err"}, rsp_err, exp_err);

        snap_data = rsp_data;
        snap_err  = rsp_err;
        stab_bad  = 0;
        if (pend) begin
            cmd_valid     = 1'b1;
            cmd_chan_mask = '0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== snap_data || rsp_err !== snap_err ||
                cmd_ready !== 1'b0) stab_bad++;
        end
        if (hold > 0) check_eq({tag, "_hold"}, stab_bad, 0);

        rsp_ready = 1'b1;
        if (pend) check_eq({tag, "_rdy_on_retire"}, cmd_ready, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_retired"}, rsp_valid, 1'b0);
        if (pend) begin
            check_eq({tag, "_rdy_after"}, cmd_ready, 1'b1);
            @(negedge clk);
            cmd_valid = 1'b0;
            check_eq({tag, "_pend_rsp"}, rsp_valid, 1'b1);
            check_eq({tag, "_pend_data"}, rsp_data, '0);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check_eq({tag, "_pend_retired"}, rsp_valid, 1'b0);
        end
    endtask

    initial begin
        int tries;
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_chan_mask = '0;
        cmd_data      = '0;
        rsp_ready     = 1'b0;
        inv_par       = '0;
        for (int k = 0; k < N_CH; k++) set_word(k, '0, 1'b0);
        mon_reset('0, '0);

        repeat (3) @(negedge clk);
        check_eq("reset_outs", {cmd_ready, rsp_valid, busy_out, serial_clk_out, serial_data_out,
                                rsp_err}, '0);
        check_eq("reset_data", rsp_data, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single channel loopback.
        run_txn("t1", 4'b0001, 16'hA5C3, 4'b0001, 0, 1'b0);

        // All channels, ch2 tied high.
        set_word(2, 16'hFFFF, 1'b0);
        run_txn("t2", 4'b1111, 16'hA5C3, 4'b1011, 0, 1'b0);

        // Empty mask.
        run_txn("t3", 4'b0000, 16'h1234, 4'b0000, 0, 1'b0);

        // Response back-pressure with a pending command.
        run_txn("t4", 4'b0110, 16'h5A5A, 4'b0110, 10, 1'b1);

        // Reset mid-transfer.
        mon_reset(4'b1111, 4'b1111);
        cmd_valid     = 1'b1;
        cmd_chan_mask = 4'b1111;
        cmd_data      = 16'hC3A5;
        @(negedge clk);
        cmd_valid = 1'b0;
        tries = 0;
        forever begin
            monitor();
            if (rises[0] >= 7 || tries >= 500) break;
            @(negedge clk);
            tries++;
        end
        check_eq("t5_reach_bit7", rises[0], 7);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t5_abort", {serial_clk_out, serial_data_out, busy_out, rsp_valid, cmd_ready},
                 '0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("t5_idle", {rsp_valid, cmd_ready}, 2'b01);
        run_txn("t5_t1", 4'b0001, 16'hA5C3, 4'b0001, 0, 1'b0);

`ifdef MIC_ARRAY_PARITY_EN
        // Corrupted parity on ch1 only.
        set_word(1, 16'h0001, 1'b1);
        run_txn("t6", 4'b1111, 16'h0001, 4'b1101, 0, 1'b0);
        set_word(1, 16'h0001, 1'b0);
`endif

        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < N_CH; k++) begin
                set_word(k, DATA_W'($urandom), 1'($urandom_range(0, 1)));
            end
            run_txn($sformatf("rnd%0d", n), N_CH'($urandom_range(0, 15)), DATA_W'($urandom),
                    N_CH'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
